// File: rtl/prism_sp_puzzle_sw_fifo_port_pkg.sv
// Shared register map and bit positions for the software puzzle FIFO endpoint.
package prism_sp_pkg;

  typedef enum logic [1:0] {
    REG_TXDATA  = 2'd0,
    REG_RXDATA  = 2'd1,
    REG_STATUS  = 2'd2,
    REG_CONTROL = 2'd3
  } reg_addr_e;

  localparam int ST_TX_LEVEL_LSB = 0;
  localparam int ST_RX_LEVEL_LSB = 8;
  localparam int ST_TX_FULL      = 16;
  localparam int ST_RX_EMPTY     = 17;
  localparam int ST_TX_OVF       = 18;
  localparam int ST_TX_UDF       = 19;
  localparam int ST_RX_OVF       = 20;
  localparam int ST_RX_UDF       = 21;

  localparam int CTL_FLUSH_TX    = 0;
  localparam int CTL_FLUSH_RX    = 1;
  localparam int CTL_CLR_STICKY  = 2;

endpackage

// File: rtl/prism_sp_puzzle_sw_fifo_port_if.sv
// CPU register bus plus puzzle fifo_read/fifo_write channels of the software endpoint.
interface prism_sp_puzzle_sw_fifo_port_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  reg_wr_en;
  logic                  reg_rd_en;
  logic [1:0]            reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic [DATA_WIDTH-1:0] reg_rdata;
  logic                  reg_rvalid;
  logic                  fr_rd_en;
  logic [DATA_WIDTH-1:0] fr_rd_data;
  logic                  fr_empty;
  logic                  fw_wr_en;
  logic [DATA_WIDTH-1:0] fw_wr_data;
  logic                  fw_full;
  logic                  irq;

  modport master (
    output reg_wr_en, reg_rd_en, reg_addr, reg_wdata, fr_rd_en, fw_wr_en, fw_wr_data,
    input  reg_rdata, reg_rvalid, fr_rd_data, fr_empty, fw_full, irq
  );

  modport slave (
    input  reg_wr_en, reg_rd_en, reg_addr, reg_wdata, fr_rd_en, fw_wr_en, fw_wr_data,
    output reg_rdata, reg_rvalid, fr_rd_data, fr_empty, fw_full, irq
  );
endinterface

// File: rtl/prism_sp_puzzle_sw_fifo_port_sync_fifo.sv
// Synchronous FWFT FIFO with level, flush and single-cycle overflow/underflow pulses.
module prism_sp_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty,
  output logic                    ovf,
  output logic                    udf
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // Full/empty gate push/pop from the pre-edge level; flush suppresses both and their flags.
  always_comb begin
    full    = (level == LEVEL_W'(DEPTH));
    empty   = (level == '0);
    push_ok = push && !full && !flush;
    pop_ok  = pop && !empty && !flush;
    ovf     = push && full && !flush;
    udf     = pop && empty && !flush;
    dout    = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/prism_sp_puzzle_sw_fifo_port.sv
// Software endpoint for one puzzle FIFO channel pair: TX/RX queues, register decode,
// sticky error flags and the registered read-data path.
module prism_sp_puzzle_sw_fifo_port
  import prism_sp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input logic                          clock,
  input logic                          reset,
  prism_sp_puzzle_sw_fifo_port_if.slave bus
);
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  reg_addr_e             addr;
  logic                  ctl_wr;
  logic                  tx_push;
  logic                  tx_flush;
  logic                  rx_pop;
  logic                  rx_flush;
  logic                  clr_sticky;
  logic                  rx_hit;

  logic [DATA_WIDTH-1:0] tx_head;
  logic [DATA_WIDTH-1:0] rx_head;
  logic [LEVEL_W-1:0]    tx_level;
  logic [LEVEL_W-1:0]    rx_level;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  rx_full;
  logic                  rx_empty;
  logic                  tx_ovf_p;
  logic                  tx_udf_p;
  logic                  rx_ovf_p;
  logic                  rx_udf_p;

  logic                  tx_ovf_q;
  logic                  tx_udf_q;
  logic                  rx_ovf_q;
  logic                  rx_udf_q;

  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  assign addr = reg_addr_e'(bus.reg_addr);

  always_comb begin
    ctl_wr     = bus.reg_wr_en && (addr == REG_CONTROL);
    tx_push    = bus.reg_wr_en && (addr == REG_TXDATA);
    rx_pop     = bus.reg_rd_en && (addr == REG_RXDATA);
    tx_flush   = ctl_wr && bus.reg_wdata[CTL_FLUSH_TX];
    rx_flush   = ctl_wr && bus.reg_wdata[CTL_FLUSH_RX];
    clr_sticky = ctl_wr && bus.reg_wdata[CTL_CLR_STICKY];
    rx_hit     = rx_pop && !rx_empty && !rx_flush;
  end

  prism_sp_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_tx_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (tx_push),
    .pop   (bus.fr_rd_en),
    .flush (tx_flush),
    .din   (bus.reg_wdata),
    .dout  (tx_head),
    .level (tx_level),
    .full  (tx_full),
    .empty (tx_empty),
    .ovf   (tx_ovf_p),
    .udf   (tx_udf_p)
  );

  prism_sp_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_rx_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (bus.fw_wr_en),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (bus.fw_wr_data),
    .dout  (rx_head),
    .level (rx_level),
    .full  (rx_full),
    .empty (rx_empty),
    .ovf   (rx_ovf_p),
    .udf   (rx_udf_p)
  );

  always_comb begin
    status                              = '0;
    status[ST_TX_LEVEL_LSB +: LEVEL_W]  = tx_level;
    status[ST_RX_LEVEL_LSB +: LEVEL_W]  = rx_level;
    status[ST_TX_FULL]                  = tx_full;
    status[ST_RX_EMPTY]                 = rx_empty;
    status[ST_TX_OVF]                   = tx_ovf_q;
    status[ST_TX_UDF]                   = tx_udf_q;
    status[ST_RX_OVF]                   = rx_ovf_q;
    status[ST_RX_UDF]                   = rx_udf_q;
  end

  always_comb begin
    rdata_d = '0;
    if (bus.reg_rd_en) begin
      unique case (addr)
        REG_RXDATA: rdata_d = rx_hit ? rx_head : '0;
        REG_STATUS: rdata_d = status;
        default:    rdata_d = '0;
      endcase
    end
  end

  // A fresh error pulse outranks a same-cycle clear so no event is lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_ovf_q <= 1'b0;
      tx_udf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      tx_ovf_q <= (tx_ovf_q && !clr_sticky) || tx_ovf_p;
      tx_udf_q <= (tx_udf_q && !clr_sticky) || tx_udf_p;
      rx_ovf_q <= (rx_ovf_q && !clr_sticky) || rx_ovf_p;
      rx_udf_q <= (rx_udf_q && !clr_sticky) || rx_udf_p;
      rdata_q  <= rdata_d;
      rvalid_q <= bus.reg_rd_en;
    end
  end

  assign bus.reg_rdata  = rdata_q;
  assign bus.reg_rvalid = rvalid_q;
  assign bus.fr_rd_data = tx_head;
  assign bus.fr_empty   = tx_empty;
  assign bus.fw_full    = rx_full;
  assign bus.irq        = !rx_empty || tx_ovf_q || tx_udf_q || rx_ovf_q || rx_udf_q;

endmodule

// File: tb/tb_prism_sp_puzzle_sw_fifo_port.sv
// Randomized plus directed bench for the software puzzle FIFO endpoint, checked against a queue model.
module tb_prism_sp_puzzle_sw_fifo_port;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  prism_sp_puzzle_sw_fifo_port_if #(.DATA_WIDTH(DW)) bus();

  prism_sp_puzzle_sw_fifo_port #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  bit          f_txovf, f_txudf, f_rxovf, f_rxudf;
  bit          exp_rvalid;
  logic [31:0] exp_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare every output after the edge.
  task automatic cyc(input bit rst, input bit w, input bit r, input logic [1:0] a,
                     input logic [31:0] d, input bit frd, input bit fwr, input logic [31:0] fd);
    bit ctl, ftx, frx, clr, txpop, rxpop, nto, ntu, nro, nru;
    int txn, rxn;
    logic [31:0] st;
    reset          = rst;
    bus.reg_wr_en  = w;
    bus.reg_rd_en  = r;
    bus.reg_addr   = a;
    bus.reg_wdata  = d;
    bus.fr_rd_en   = frd;
    bus.fw_wr_en   = fwr;
    bus.fw_wr_data = fd;
    if (rst) begin
      tx_q.delete();
      rx_q.delete();
      {f_txovf, f_txudf, f_rxovf, f_rxudf} = '0;
      exp_rvalid = 1'b0;
      exp_rdata  = '0;
    end else begin
      ctl = w && (a == 2'd3);
      ftx = ctl && d[0];
      frx = ctl && d[1];
      clr = ctl && d[2];
      txn = tx_q.size();
      rxn = rx_q.size();
      {txpop, rxpop, nto, ntu, nro, nru} = '0;
      exp_rvalid = r;
      exp_rdata  = '0;
      if (r && a == 2'd1 && !frx) begin
        if (rxn > 0) begin
          exp_rdata = rx_q[0];
          rxpop = 1'b1;
        end else begin
          nru = 1'b1;
        end
      end
      if (r && a == 2'd2) begin
        st = 32'(txn) | (32'(rxn) << 8);
        st[16] = (txn == DEPTH);
        st[17] = (rxn == 0);
        st[18] = f_txovf;
        st[19] = f_txudf;
        st[20] = f_rxovf;
        st[21] = f_rxudf;
        exp_rdata = st;
      end
      if (ftx) begin
        tx_q.delete();
      end else begin
        if (frd) begin
          if (txn > 0) txpop = 1'b1;
          else ntu = 1'b1;
        end
        if (txpop) void'(tx_q.pop_front());
        if (w && a == 2'd0) begin
          if (txn < DEPTH) tx_q.push_back(d);
          else nto = 1'b1;
        end
      end
      if (frx) begin
        rx_q.delete();
      end else begin
        if (rxpop) void'(rx_q.pop_front());
        if (fwr) begin
          if (rxn < DEPTH) rx_q.push_back(fd);
          else nro = 1'b1;
        end
      end
      f_txovf = (f_txovf && !clr) || nto;
      f_txudf = (f_txudf && !clr) || ntu;
      f_rxovf = (f_rxovf && !clr) || nro;
      f_rxudf = (f_rxudf && !clr) || nru;
    end
    @(posedge clock);
    #1;
    check("fr_empty", bus.fr_empty, tx_q.size() == 0);
    check("fr_rd_data", bus.fr_rd_data, (tx_q.size() == 0) ? 32'h0 : tx_q[0]);
    check("fw_full", bus.fw_full, rx_q.size() == DEPTH);
    check("irq", bus.irq, (rx_q.size() != 0) || f_txovf || f_txudf || f_rxovf || f_rxudf);
    check("reg_rvalid", bus.reg_rvalid, exp_rvalid);
    if (exp_rvalid || rst) check("reg_rdata", bus.reg_rdata, exp_rdata);
  endtask

  task automatic idle();                                  cyc(0, 0, 0, 2'd0, 0, 0, 0, 0); endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d); cyc(0, 1, 0, a, d, 0, 0, 0); endtask
  task automatic rd(input logic [1:0] a);                  cyc(0, 0, 1, a, 0, 0, 0, 0);    endtask
  task automatic frpop();                                  cyc(0, 0, 0, 2'd0, 0, 1, 0, 0); endtask
  task automatic fwpush(input logic [31:0] d);             cyc(0, 0, 0, 2'd0, 0, 0, 1, d); endtask

  initial begin
    bit          w, r, frd, fwr, rst;
    logic [1:0]  a;
    logic [31:0] d;
    int unsigned bias;

    cyc(1, 0, 0, 2'd0, 0, 0, 0, 0);
    cyc(1, 0, 0, 2'd0, 0, 0, 0, 0);
    check("rst_fr_empty", bus.fr_empty, 1);
    check("rst_irq", bus.irq, 0);
    check("rst_fw_full", bus.fw_full, 0);
    check("rst_rdata", bus.reg_rdata, 0);

    for (int i = 1; i <= 3; i++) wr(2'd0, 32'hA5A5_0000 + 32'(i));
    check("tx_head_first", bus.fr_rd_data, 32'hA5A5_0001);
    for (int i = 0; i < 3; i++) frpop();
    check("tx_drained", bus.fr_empty, 1);

    fwpush(32'h11);
    fwpush(32'h22);
    rd(2'd2);
    check("st_rx_level2", (bus.reg_rdata >> 8) & 32'h1f, 2);
    rd(2'd1);
    check("rx_read_11", bus.reg_rdata, 32'h11);
    rd(2'd1);
    check("rx_read_22", bus.reg_rdata, 32'h22);
    check("rx_empty_irq", bus.irq, 0);

    for (int i = 0; i < 17; i++) wr(2'd0, 32'(i) + 32'h100);
    rd(2'd2);
    check("st_tx_full", bus.reg_rdata[16], 1);
    check("st_tx_ovf", bus.reg_rdata[18], 1);
    wr(2'd3, 32'h4);
    check("clr_irq", bus.irq, 0);
    for (int i = 0; i < 16; i++) frpop();

    rd(2'd1);
    check("rx_udf_rdata", bus.reg_rdata, 0);
    rd(2'd2);
    check("st_rx_udf", bus.reg_rdata[21], 1);
    frpop();
    rd(2'd2);
    check("st_tx_udf", bus.reg_rdata[19], 1);
    wr(2'd3, 32'h4);

    for (int i = 0; i < 16; i++) fwpush(32'h200 + 32'(i));
    cyc(0, 0, 1, 2'd1, 0, 0, 1, 32'hDEAD);
    check("rx_full_pop_data", bus.reg_rdata, 32'h200);
    rd(2'd2);
    check("st_rx_ovf_level", bus.reg_rdata & 32'h0010_1f00, 32'h0010_0f00);
    cyc(0, 1, 0, 2'd0, 32'h77, 1, 0, 0);
    rd(2'd2);
    check("st_tx_udf_level", bus.reg_rdata & 32'h0008_001f, 32'h0008_0001);
    wr(2'd3, 32'h7);

    for (int i = 0; i < 5; i++) wr(2'd0, 32'h300 + 32'(i));
    cyc(0, 1, 0, 2'd3, 32'h1, 1, 0, 0);
    rd(2'd2);
    check("flush_tx_status", bus.reg_rdata & 32'h000c_001f, 0);
    for (int i = 0; i < 4; i++) begin
      wr(2'd0, 32'h400 + 32'(i));
      fwpush(32'h500 + 32'(i));
    end
    cyc(1, 1, 1, 2'd1, 32'h9, 1, 1, 32'h9);
    check("midrst_fr_empty", bus.fr_empty, 1);
    check("midrst_irq", bus.irq, 0);
    check("midrst_rvalid", bus.reg_rvalid, 0);

    for (int i = 0; i < 3000; i++) begin
      bias = (i / 150) % 2;
      rst  = ($urandom_range(0, 699) == 0);
      w    = ($urandom_range(0, 2) != 0) ? (bias == 0) : ($urandom_range(0, 3) == 0);
      r    = ($urandom_range(0, 2) == 0);
      a    = 2'($urandom_range(0, 3));
      if (w && a == 2'd3 && $urandom_range(0, 4) != 0) a = 2'd0;
      if (w && r && $urandom_range(0, 1) == 0) a = 2'd2;
      d    = $urandom;
      if (w && a == 2'd3) d = 32'($urandom_range(0, 7));
      frd  = ($urandom_range(0, 3) == 0) ^ (bias == 1);
      fwr  = ($urandom_range(0, 3) != 0) ^ (bias == 1);
      if (!w && !r && $urandom_range(0, 1) == 0) begin
        r = 1'b1;
        a = 2'd1;
      end
      cyc(rst, w, r, a, d, frd, fwr, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
